// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: instruction width, NOP encoding and
// the fetch-stage state encoding.
package mips_pkg;

   localparam int INSTR_W = 32;

   // All-zero word is SLL $0,$0,0, the canonical MIPS NOP
   localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational redirect target generation for J/JAL, JR and taken
// BEQ/BNE, resolved against the IF/ID pc+4 with priority jr > jump > branch.
module branch_target_calc #(
   parameter int ADDR_W = 32
) (
   input  logic              jump,
   input  logic              jr,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] pc4,
   input  logic [25:0]       instr_index,
   input  logic [ADDR_W-1:0] jr_target,
   input  logic [15:0]       branch_offset,
   output logic              redirect,
   output logic [ADDR_W-1:0] target
);

   logic [ADDR_W-1:0] offset_ext;
   logic [ADDR_W-1:0] jump_addr;
   logic [ADDR_W-1:0] branch_addr;
   logic [ADDR_W-1:0] jr_addr;

   // Word offset shifted left by two and sign-extended to address width
   assign offset_ext[1:0] = 2'b00;
   generate
      for (genvar gi = 0; gi < ADDR_W - 2; gi++) begin : g_sext
         if (gi < 16) begin : g_low
            assign offset_ext[gi+2] = branch_offset[gi];
         end else begin : g_sign
            assign offset_ext[gi+2] = branch_offset[15];
         end
      end
   endgenerate

   // Jump keeps the top region bits of the delay-slot-free pc+4
   assign jump_addr   = {pc4[ADDR_W-1:28], instr_index, 2'b00};
   assign branch_addr = pc4 + offset_ext;
   // Force word alignment so imem_addr never carries stray low bits
   assign jr_addr     = {jr_target[ADDR_W-1:2], 2'b00};

   assign redirect = jr | jump | branch_taken;

   // Priority select of the redirect target
   always_comb begin
      target = branch_addr;
      if (jr) begin
         target = jr_addr;
      end else if (jump) begin
         target = jump_addr;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives instruction memory requests,
// and holds the IF/ID register feeding decode. Handles decode stalls via a
// one-entry HOLD buffer and squashes obsolete in-flight fetches via DRAIN.
module fetch_stage
   import mips_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               jump,
   input  logic               jr,
   input  logic               branch_taken,
   input  logic [25:0]        instr_index,
   input  logic [ADDR_W-1:0]  jr_target,
   input  logic [15:0]        branch_offset,
   output logic               imem_en,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_ack,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [ADDR_W-1:0]  if_id_pc4,
   output logic               if_id_valid
);

   localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

   fetch_state_t       state_reg, state_next;
   logic [ADDR_W-1:0]  pc_reg, pc_next;
   logic [ADDR_W-1:0]  saved_target_reg, saved_target_next;
   logic [INSTR_W-1:0] buf_instr_reg, buf_instr_next;
   logic [ADDR_W-1:0]  buf_pc4_reg, buf_pc4_next;
   logic [INSTR_W-1:0] if_id_instr_reg, if_id_instr_next;
   logic [ADDR_W-1:0]  if_id_pc4_reg, if_id_pc4_next;
   logic               if_id_valid_reg, if_id_valid_next;

   logic               redirect_req;
   logic               redirect_accept;
   logic [ADDR_W-1:0]  redirect_target;
   logic [ADDR_W-1:0]  pc_plus4;

   branch_target_calc #(
      .ADDR_W (ADDR_W)
   ) u_target (
      .jump          (jump),
      .jr            (jr),
      .branch_taken  (branch_taken),
      .pc4           (if_id_pc4_reg),
      .instr_index   (instr_index),
      .jr_target     (jr_target),
      .branch_offset (branch_offset),
      .redirect      (redirect_req),
      .target        (redirect_target)
   );

   // Decode only steers fetch when it is actually advancing
   assign redirect_accept = redirect_req & ~stall;
   assign pc_plus4        = pc_reg + WORD_BYTES;

   assign imem_addr   = pc_reg;
   assign if_id_instr = if_id_instr_reg;
   assign if_id_pc4   = if_id_pc4_reg;
   assign if_id_valid = if_id_valid_reg;

   // Next-state, datapath and request-enable decode
   always_comb begin
      state_next        = state_reg;
      pc_next           = pc_reg;
      saved_target_next = saved_target_reg;
      buf_instr_next    = buf_instr_reg;
      buf_pc4_next      = buf_pc4_reg;
      if_id_instr_next  = if_id_instr_reg;
      if_id_pc4_next    = if_id_pc4_reg;
      if_id_valid_next  = if_id_valid_reg;
      imem_en           = rst_n && (state_reg != HOLD);

      case (state_reg)
         FETCH: begin
            if (stall) begin
               // Park the returning word; IF/ID is frozen by decode
               if (imem_ack) begin
                  buf_instr_next = imem_rdata;
                  buf_pc4_next   = pc_plus4;
                  pc_next        = pc_plus4;
                  state_next     = HOLD;
               end
            end else if (redirect_accept) begin
               if_id_valid_next = 1'b0;
               if_id_instr_next = NOP_INSTR;
               if (imem_ack) begin
                  pc_next = redirect_target;
               end else begin
                  // Request still outstanding: wait it out before retargeting
                  saved_target_next = redirect_target;
                  state_next        = DRAIN;
               end
            end else if (imem_ack) begin
               if_id_instr_next = imem_rdata;
               if_id_pc4_next   = pc_plus4;
               if_id_valid_next = 1'b1;
               pc_next          = pc_plus4;
            end else begin
               if_id_valid_next = 1'b0;
            end
         end

         HOLD: begin
            if (!stall) begin
               state_next = FETCH;
               if (redirect_accept) begin
                  if_id_valid_next = 1'b0;
                  if_id_instr_next = NOP_INSTR;
                  pc_next          = redirect_target;
               end else begin
                  if_id_instr_next = buf_instr_reg;
                  if_id_pc4_next   = buf_pc4_reg;
                  if_id_valid_next = 1'b1;
               end
            end
         end

         DRAIN: begin
            // Stale response is swallowed; nothing real reaches decode
            if_id_valid_next = 1'b0;
            if (imem_ack) begin
               pc_next    = saved_target_reg;
               state_next = FETCH;
            end
         end

         default: begin
            state_next = FETCH;
         end
      endcase
   end

   // State and pipeline registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg        <= FETCH;
         pc_reg           <= RESET_PC;
         saved_target_reg <= RESET_PC;
         buf_instr_reg    <= NOP_INSTR;
         buf_pc4_reg      <= '0;
         if_id_instr_reg  <= NOP_INSTR;
         if_id_pc4_reg    <= '0;
         if_id_valid_reg  <= 1'b0;
      end else begin
         state_reg        <= state_next;
         pc_reg           <= pc_next;
         saved_target_reg <= saved_target_next;
         buf_instr_reg    <= buf_instr_next;
         buf_pc4_reg      <= buf_pc4_next;
         if_id_instr_reg  <= if_id_instr_next;
         if_id_pc4_reg    <= if_id_pc4_next;
         if_id_valid_reg  <= if_id_valid_next;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized stall,
// redirect and memory-latency traffic, all checked against a program-order
// stream model of what decode should receive.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        jump;
   logic        jr;
   logic        branch_taken;
   logic [25:0] instr_index;
   logic [31:0] jr_target;
   logic [15:0] branch_offset;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;

   int          total;
   int          passed;
   int          failed;
   int          lat_mode;
   int          lat_left;
   bit          pending;
   logic [31:0] pend_addr;
   logic [31:0] exp_pc4;
   int          gap;

   always #5 clk = ~clk;

   fetch_stage #(
      .ADDR_W   (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .jump          (jump),
      .jr            (jr),
      .branch_taken  (branch_taken),
      .instr_index   (instr_index),
      .jr_target     (jr_target),
      .branch_offset (branch_offset),
      .imem_en       (imem_en),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_ack      (imem_ack),
      .if_id_instr   (if_id_instr),
      .if_id_pc4     (if_id_pc4),
      .if_id_valid   (if_id_valid)
   );

   // Instruction memory contents as a pure function of address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1234_0000;
   endfunction

   // Architectural redirect target from the decode-stage fields
   function automatic logic [31:0] model_target(input logic [31:0] pc4,
                                                input logic jr_i,
                                                input logic jump_i,
                                                input logic [25:0] idx,
                                                input logic [31:0] jrt,
                                                input logic [15:0] off);
      int so;
      if (jr_i) return jrt;
      if (jump_i) return (pc4 & 32'hF000_0000) | (32'(idx) * 32'd4);
      so = int'($signed(off));
      return pc4 + 32'(so * 4);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         failed++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic clear_redirect();
      jump         = 1'b0;
      jr           = 1'b0;
      branch_taken = 1'b0;
   endtask

   // Memory responder: each new request draws a latency, ack when it expires
   task automatic drive_imem();
      if (imem_en && !pending)
         lat_left = (lat_mode < 0) ? int'($urandom_range(2, 0)) : lat_mode;
      imem_ack   = imem_en && (lat_left == 0);
      imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom();
   endtask

   // Stream model: every instruction decode accepts must be next in program order
   task automatic scoreboard();
      if (!rst_n) begin
         exp_pc4 = 32'h0000_0004;
         gap     = 0;
      end else if (!stall && if_id_valid) begin
         check("stream_pc4", if_id_pc4, exp_pc4);
         check("stream_instr", if_id_instr, mem_word(if_id_pc4 - 32'd4));
         if (jr || jump || branch_taken)
            exp_pc4 = model_target(if_id_pc4, jr, jump, instr_index, jr_target, branch_offset) + 32'd4;
         else
            exp_pc4 = if_id_pc4 + 32'd4;
         gap = 0;
      end else if (!stall) begin
         gap++;
         if (gap > 30) begin
            check("liveness", 32'(gap), 32'd30);
            gap = 0;
         end
      end
   endtask

   task automatic tick();
      logic en_s;
      logic ack_s;
      logic [31:0] a_s;
      en_s  = imem_en;
      ack_s = imem_ack;
      a_s   = imem_addr;
      @(posedge clk);
      pending = rst_n && en_s && !ack_s;
      if (pending) lat_left--;
      pend_addr = a_s;
      @(negedge clk);
   endtask

   task automatic step();
      #1;
      drive_imem();
      scoreboard();
      if (rst_n && pending) check("addr_stable", imem_addr, pend_addr);
      tick();
   endtask

   initial begin
      total = 0; passed = 0; failed = 0;
      lat_mode = 0; lat_left = 0; pending = 1'b0; pend_addr = '0;
      exp_pc4 = 32'd4; gap = 0;
      rst_n = 1'b0; stall = 1'b0;
      clear_redirect();
      instr_index = '0; jr_target = '0; branch_offset = '0;
      imem_rdata = '0; imem_ack = 1'b0;

      // Reset state
      @(negedge clk);
      step();
      step();
      check("rst_en", imem_en, 1'b0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_valid", if_id_valid, 1'b0);
      check("rst_instr", if_id_instr, 32'h0);
      check("rst_pc4", if_id_pc4, 32'h0);

      // Zero-wait streaming
      rst_n = 1'b1;
      #1;
      check("first_en", imem_en, 1'b1);
      check("first_addr", imem_addr, 32'h0);
      step();
      check("seq_addr4", imem_addr, 32'h4);
      check("seq_pc4_4", if_id_pc4, 32'h4);
      check("seq_valid", if_id_valid, 1'b1);
      check("seq_instr0", if_id_instr, mem_word(32'h0));
      step();
      check("seq_addr8", imem_addr, 32'h8);
      check("seq_pc4_8", if_id_pc4, 32'h8);
      step();
      check("seq_addr12", imem_addr, 32'hC);
      check("seq_pc4_12", if_id_pc4, 32'hC);
      step();
      check("pre_jump_pc4", if_id_pc4, 32'h10);

      // Jump with same-cycle ack: one bubble
      jump = 1'b1; instr_index = 26'h40;
      step();
      clear_redirect();
      check("jump_addr", imem_addr, 32'h100);
      check("jump_bubble", if_id_valid, 1'b0);
      check("jump_nop", if_id_instr, 32'h0);
      step();
      check("jump_land_pc4", if_id_pc4, 32'h104);
      check("jump_land_valid", if_id_valid, 1'b1);

      // jr and jump together: jr wins
      jr = 1'b1; jump = 1'b1; jr_target = 32'h1C; instr_index = 26'h3FF;
      step();
      clear_redirect();
      check("jr_prio_addr", imem_addr, 32'h1C);
      step();
      check("jr_land_pc4", if_id_pc4, 32'h20);

      // Backward branch
      branch_taken = 1'b1; branch_offset = 16'hFFFE;
      step();
      clear_redirect();
      check("br_addr", imem_addr, 32'h18);
      check("br_bubble", if_id_valid, 1'b0);
      step();
      check("br_land_pc4", if_id_pc4, 32'h1C);
      check("br_land_addr", imem_addr, 32'h1C);

      // Three stall cycles with ack: buffer word, freeze IF/ID
      stall = 1'b1;
      step();
      for (int i = 0; i < 2; i++) begin
         check("hold_en", imem_en, 1'b0);
         check("hold_pc4", if_id_pc4, 32'h1C);
         check("hold_instr", if_id_instr, mem_word(32'h18));
         check("hold_valid", if_id_valid, 1'b1);
         step();
      end
      stall = 1'b0;
      step();
      check("unhold_pc4", if_id_pc4, 32'h20);
      check("unhold_instr", if_id_instr, mem_word(32'h1C));
      check("unhold_valid", if_id_valid, 1'b1);
      check("unhold_addr", imem_addr, 32'h20);

      // Redirect while the request is 3 cycles from ack: drain
      lat_mode = 3;
      jump = 1'b1; instr_index = 26'h80;
      step();
      clear_redirect();
      lat_mode = 0;
      for (int i = 0; i < 3; i++) begin
         check("drain_addr", imem_addr, 32'h20);
         check("drain_en", imem_en, 1'b1);
         check("drain_valid", if_id_valid, 1'b0);
         step();
      end
      check("drain_target", imem_addr, 32'h200);
      check("drain_no_stale", if_id_valid, 1'b0);
      step();
      check("drain_land_pc4", if_id_pc4, 32'h204);

      // Reset in the middle of a drain
      lat_mode = 3;
      jump = 1'b1; instr_index = 26'h100;
      step();
      clear_redirect();
      lat_mode = 0;
      check("drain2_addr", imem_addr, 32'h204);
      rst_n = 1'b0;
      #1;
      check("rst_mid_en", imem_en, 1'b0);
      step();
      check("rst_mid_addr", imem_addr, 32'h0);
      check("rst_mid_valid", if_id_valid, 1'b0);
      check("rst_mid_pc4", if_id_pc4, 32'h0);
      step();
      rst_n = 1'b1;
      #1;
      check("restart_addr", imem_addr, 32'h0);
      step();
      check("restart_pc4", if_id_pc4, 32'h4);

      // PC wrap at the top of the address space
      jr = 1'b1; jr_target = 32'hFFFF_FFF8;
      step();
      clear_redirect();
      check("wrap_pre_addr", imem_addr, 32'hFFFF_FFF8);
      step();
      check("wrap_last_addr", imem_addr, 32'hFFFF_FFFC);
      step();
      check("wrap_addr", imem_addr, 32'h0);
      check("wrap_pc4", if_id_pc4, 32'h0);

      // Randomized traffic against the stream model
      lat_mode = -1;
      for (int n = 0; n < 3000; n++) begin
         stall = ($urandom_range(3, 0) == 0);
         clear_redirect();
         if (if_id_valid && $urandom_range(4, 0) == 0) begin
            jr_target     = $urandom() & 32'hFFFF_FFFC;
            instr_index   = 26'($urandom());
            branch_offset = 16'($urandom());
            case ($urandom_range(3, 0))
               0: jr = 1'b1;
               1: jump = 1'b1;
               2: branch_taken = 1'b1;
               default: begin
                  jump = 1'b1;
                  branch_taken = 1'b1;
               end
            endcase
         end
         step();
      end
      clear_redirect();
      stall = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
